// File: rtl/musa_pkg.sv
// rtl/musa_pkg.sv - shared opcode, state and pc_sel encodings for the MUSA sequencer
package musa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IF    = 3'd1,
        ST_ID    = 3'd2,
        ST_EX    = 3'd3,
        ST_MEM   = 3'd4,
        ST_WB    = 3'd5,
        ST_HALT  = 3'd6,
        ST_FAULT = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_NOP  = 6'b000001;
    localparam logic [5:0] OP_HALT = 6'b000010;
    localparam logic [5:0] OP_CALL = 6'b000011;
    localparam logic [5:0] OP_RET  = 6'b000111;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_JPC  = 6'b001001;
    localparam logic [5:0] OP_JR   = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BRFL = 6'b010001;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [1:0] PC_SEL_INC = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_STK = 2'b10;

    function automatic logic op_defined(input logic [5:0] op);
        case (op)
            OP_R, OP_NOP, OP_HALT, OP_CALL, OP_RET, OP_ADDI, OP_JPC, OP_JR,
            OP_SUBI, OP_ANDI, OP_ORI, OP_BRFL, OP_LW, OP_SW: op_defined = 1'b1;
            default: op_defined = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/musa_seq_depth_ctr.sv
// rtl/musa_seq_depth_ctr.sv - call-stack depth counter with full/empty guards
module musa_seq_depth_ctr #(
    parameter int STACK_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] depth,
    output logic       full,
    output logic       empty
);

    assign full  = (depth == 4'(STACK_DEPTH));
    assign empty = (depth == 4'd0);

    // Guards make a stray inc/dec at the limits harmless even if the FSM misbehaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= 4'd0;
        end else if (inc && !full) begin
            depth <= depth + 4'd1;
        end else if (dec && !empty) begin
            depth <= depth - 4'd1;
        end
    end

endmodule

// File: rtl/musa_stage_sequencer.sv
// rtl/musa_stage_sequencer.sv - multi-cycle IF/ID/EX/MEM/WB control FSM; MUSA_SEQ_PERF_CNT_EN adds retired_cnt
module musa_stage_sequencer
    import musa_pkg::*;
#(
    parameter int STACK_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] imem_rdata_op,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       brfl_taken,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       rf_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       push,
    output logic       pop,
    output logic [2:0] state,
    output logic       halted,
    output logic       fault,
    output logic [3:0] stack_depth
`ifdef MUSA_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    state_t     cur_state, nxt_state;
    logic [5:0] op_q;
    logic       stk_full, stk_empty;

    musa_seq_depth_ctr #(.STACK_DEPTH(STACK_DEPTH)) u_depth (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .dec   (pop),
        .depth (stack_depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_IDLE;
            op_q      <= 6'b000000;
        end else begin
            cur_state <= nxt_state;
            if (ir_we) op_q <= imem_rdata_op;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_INC;
        push      = 1'b0;
        pop       = 1'b0;
        case (cur_state)
            ST_IDLE: if (start) nxt_state = ST_IF;
            ST_IF: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we     = 1'b1;
                    nxt_state = ST_ID;
                end
            end
            ST_ID: begin
                if (op_q == OP_HALT) begin
                    nxt_state = ST_HALT;
                end else if (op_q == OP_NOP) begin
                    pc_we     = 1'b1;
                    nxt_state = ST_IF;
                end else if (!op_defined(op_q)) begin
                    nxt_state = ST_FAULT;
                end else begin
                    nxt_state = ST_EX;
                end
            end
            ST_EX: begin
                case (op_q)
                    OP_R, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: nxt_state = ST_WB;
                    OP_LW, OP_SW: nxt_state = ST_MEM;
                    OP_JR, OP_JPC: begin
                        pc_we     = 1'b1;
                        pc_sel    = PC_SEL_BR;
                        nxt_state = ST_IF;
                    end
                    OP_BRFL: begin
                        pc_we     = 1'b1;
                        pc_sel    = brfl_taken ? PC_SEL_BR : PC_SEL_INC;
                        nxt_state = ST_IF;
                    end
                    OP_CALL: begin
                        if (stk_full) begin
                            nxt_state = ST_FAULT;
                        end else begin
                            push      = 1'b1;
                            pc_we     = 1'b1;
                            pc_sel    = PC_SEL_BR;
                            nxt_state = ST_IF;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            nxt_state = ST_FAULT;
                        end else begin
                            pop       = 1'b1;
                            pc_we     = 1'b1;
                            pc_sel    = PC_SEL_STK;
                            nxt_state = ST_IF;
                        end
                    end
                    default: nxt_state = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_SW);
                if (dmem_ready) begin
                    if (op_q == OP_SW) begin
                        pc_we     = 1'b1;
                        nxt_state = ST_IF;
                    end else begin
                        nxt_state = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                nxt_state = ST_IF;
            end
            ST_HALT:  nxt_state = ST_HALT;
            ST_FAULT: nxt_state = ST_FAULT;
            default:  nxt_state = ST_FAULT;
        endcase
    end

    assign state  = cur_state;
    assign halted = (cur_state == ST_HALT);
    assign fault  = (cur_state == ST_FAULT);

`ifdef MUSA_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_cnt <= 32'd0;
        else if (pc_we) retired_cnt <= retired_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/musa_stage_sequencer.md
MUSA_STAGE_SEQUENCER -- requirements
Module: musa_stage_sequencer

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8, meaning the maximum number of nested CALLs tracked (1..15).
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  leave IDLE; imem_rdata_op  in  6  opcode field of the fetched word; imem_ready  in  1  fetch complete; dmem_ready  in  1  data access complete; brfl_taken  in  1  BRFL flag condition from datapath.
REQ-004 SHALL have ports: imem_req  out  1; ir_we  out  1; dmem_req  out  1; dmem_we  out  1; rf_we  out  1; pc_we  out  1; pc_sel  out  2  (00 pc+1, 01 branch target, 10 stack top); push  out  1; pop  out  1.
REQ-005 SHALL have ports: state  out  3  current FSM state; halted  out  1; fault  out  1; stack_depth  out  4.

Function
REQ-006 SHALL implement a one-hot-free FSM with 3-bit encoding: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6, FAULT=7.
REQ-007 SHALL in IDLE wait for start=1, then go to IF next cycle.
REQ-008 SHALL in IF assert imem_req; when imem_ready=1, assert ir_we the same cycle, latch imem_rdata_op into an internal opcode register, and go to ID; otherwise remain in IF.
REQ-009 SHALL in ID (one cycle) decode the latched opcode: HALT -> HALT; NOP -> IF with pc_we=1, pc_sel=00; undefined opcode -> FAULT; all others -> EX.
REQ-010 SHALL in EX (one cycle) route: R, ADDI, SUBI, ANDI, ORI -> WB; LW, SW -> MEM; JR, JPC -> IF with pc_we=1, pc_sel=01.
REQ-011 SHALL in EX for BRFL go to IF with pc_we=1 and pc_sel=01 if brfl_taken=1, otherwise pc_sel=00.
REQ-012 SHALL in EX for CALL: if stack_depth==STACK_DEPTH go to FAULT with no push and no pc_we; otherwise assert push, pc_we, pc_sel=01, increment stack_depth, and go to IF.
REQ-013 SHALL in EX for RET: if stack_depth==0 go to FAULT with no pop and no pc_we; otherwise assert pop, pc_we, pc_sel=10, decrement stack_depth, and go to IF.
REQ-014 SHALL in MEM assert dmem_req (dmem_we=1 for SW) until dmem_ready=1, then: LW -> WB; SW -> IF with pc_we=1, pc_sel=00.
REQ-015 SHALL in WB (one cycle) assert rf_we, pc_we, pc_sel=00 and go to IF.
REQ-016 SHALL make all control outputs combinational from state, latched opcode, brfl_taken and ready inputs; each of rf_we, pc_we, push, pop, ir_we SHALL be high for exactly one cycle per instruction.
REQ-017 SHALL hold pc_sel=00 and every strobe at 0 in IDLE, HALT and FAULT; halted=1 only in HALT; fault=1 only in FAULT.
REQ-018 SHALL keep HALT and FAULT absorbing; the only exit is reset.
REQ-019 SHALL ignore start outside IDLE.
REQ-020 SHALL retire instructions with these latencies from the first IF cycle, with zero wait states: NOP 2 cycles; jumps, CALL and RET 3; ALU ops 4; SW 4; LW 5.

Reset
REQ-021 SHALL on rst_n=0 asynchronously force state=IDLE, opcode register=000000, stack_depth=0, and all outputs to 0.
REQ-022 SHALL on reset during MEM or IF abandon the access at once, with no pc_we or rf_we issued.

Configuration
REQ-023 SHALL, when MUSA_SEQ_PERF_CNT_EN is defined, add output retired_cnt  out  32, incremented on every pc_we (wrapping 0xFFFFFFFF->0) and reset to 0.
REQ-024 SHALL, without MUSA_SEQ_PERF_CNT_EN, omit retired_cnt and all counter logic.

Structure
REQ-025 SHALL take opcode constants (R=000000, NOP=000001, HALT=000010, CALL=000011, RET=000111, ADDI=001000, JPC=001001, JR=001010, SUBI=001011, ANDI=001100, ORI=001101, BRFL=010001, LW=100011, SW=101011), the state encoding and the pc_sel encodings from shared package musa_pkg.
REQ-026 SHALL place the stack-depth counter, including its overflow and underflow checks, in sub-module musa_seq_depth_ctr.

Verification
REQ-027 SHALL cover: start, then ADDI with imem_ready=1 -> states IF,ID,EX,WB; rf_we and pc_we each pulse once in WB; retired in 4 cycles.
REQ-028 SHALL cover: LW with dmem_ready held low 3 cycles -> MEM held 4 cycles with dmem_req=1 and dmem_we=0, then WB with rf_we=1.
REQ-029 SHALL cover: 8 CALLs (STACK_DEPTH=8) -> stack_depth=8; 9th CALL -> FAULT, fault=1, no push; state remains 7 until reset.
REQ-030 SHALL cover: RET with stack_depth=0 -> FAULT; and CALL then RET -> pop=1 with pc_sel=10 and stack_depth back to 0.
REQ-031 SHALL cover: BRFL with brfl_taken=0 -> pc_sel=00, and with brfl_taken=1 -> pc_sel=01; HALT -> halted=1 and further start pulses ignored.
REQ-032 SHALL cover: rst_n low mid-MEM (SW) -> state=IDLE immediately, dmem_req=0, no pc_we; with MUSA_SEQ_PERF_CNT_EN defined, retired_cnt=0.
